uart_apb_bridge: RTL and testbench

Parametrised APB slave front-end for the UART register file; successor of the first-generation APB decode block.
Decodes APB3 transfers into one-hot, single-cycle register write/read strobes. Supports backend-stalled accesses through a reg_ack handshake, with a timeout counter.
Drives PREADY/PSLVERR and registered PRDATA, with error checking for unmapped, misaligned and access-violating transfers.
Sits between the SoC APB fabric and the UART register-control logic (DR, RSR, LCR, ...).

---
 rtl/uart_apb_pkg.sv | 28 ++
 rtl/uart_apb_decode.sv | 38 +++
 rtl/uart_apb_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_uart_apb_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types and the UART register map for the APB front-end.
package uart_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Word offsets of the UART registers (byte address = offset * 4).
    localparam int UART_DR   = 0;
    localparam int UART_RSR  = 1;
    localparam int UART_FR   = 6;
    localparam int UART_ILPR = 8;
    localparam int UART_IBRD = 9;
    localparam int UART_FBRD = 10;
    localparam int UART_LCR  = 11;
    localparam int UART_CR   = 12;
    localparam int UART_IFLS = 13;
    localparam int UART_IMSC = 14;
    localparam int UART_RIS  = 15;

    // FR and RIS are status-only; nothing in the default map is write-only.
    localparam logic [15:0] UART_RO_MASK = 16'h8040;
    localparam logic [15:0] UART_WO_MASK = 16'h0000;

endpackage

// File: rtl/uart_apb_decode.sv
// Combinational word decode: one-hot register select plus access-error and
// write-only-read flags for a single APB address.
module uart_apb_decode #(
    parameter int                    ADDR_W   = 12,
    parameter int                    NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]   WO_MASK  = '0
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                write,
    output logic [NUM_REGS-1:0] onehot,
    output logic                err,
    output logic                wo_read
);

    localparam int IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0] word;
    logic             in_range;
    logic             ro_hit;
    logic             wo_hit;

    assign word = addr[ADDR_W-1:2];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign onehot[gi] = (word == IDX_W'(gi));
        end
    endgenerate

    assign in_range = (int'(word) < NUM_REGS);
    assign ro_hit   = |(onehot & RO_MASK);
    assign wo_hit   = |(onehot & WO_MASK);

    assign err     = (addr[1:0] != 2'b00) || !in_range || (write && ro_hit);
    assign wo_read = !write && wo_hit;

endmodule

// File: rtl/uart_apb_bridge.sv
// APB3 slave front-end for the UART register file: one-hot access strobes,
// reg_ack stall handshake with timeout. Byte strobes under UART_APB_PSTRB_EN.
module uart_apb_bridge
    import uart_apb_pkg::*;
#(
    parameter int                  ADDR_W   = 12,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] WO_MASK  = '0,
    parameter int                  TIMEOUT  = 15
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
`ifdef UART_APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]        pstrb,
    output logic [DATA_W/8-1:0]        reg_wstrb,
`endif
    output logic                       pready,
    output logic                       pslverr,
    output logic [DATA_W-1:0]          prdata,
    output logic [NUM_REGS-1:0]        reg_wr_en,
    output logic [NUM_REGS-1:0]        reg_rd_en,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    input  logic                       reg_ack,
    input  logic                       reg_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [NUM_REGS-1:0] sel_reg, sel_next;
    logic                write_reg, write_next;
    logic                nostrobe_reg, nostrobe_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [NUM_REGS-1:0] wr_en_reg, wr_en_next;
    logic [NUM_REGS-1:0] rd_en_reg, rd_en_next;
    logic                pready_reg, pready_next;
    logic                pslverr_reg, pslverr_next;
    logic [DATA_W-1:0]   prdata_reg, prdata_next;

    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_err;
    logic                dec_wo_read;
    logic                strb_err;
    logic                strb_skip;
    logic                setup;
    logic                timeout_hit;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   read_data;

    uart_apb_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .WO_MASK  (WO_MASK)
    ) u_decode (
        .addr    (paddr),
        .write   (pwrite),
        .onehot  (dec_onehot),
        .err     (dec_err),
        .wo_read (dec_wo_read)
    );

`ifdef UART_APB_PSTRB_EN
    logic [DATA_W/8-1:0] wstrb_reg;

    // A write with no lanes enabled is a legal no-op; reads must carry no lanes.
    assign strb_skip = pwrite && (pstrb == '0);
    assign strb_err  = !pwrite && (pstrb != '0);
    assign reg_wstrb = wstrb_reg;

    always_ff @(posedge pclk) begin
        if (preset)
            wstrb_reg <= '0;
        else if (state_reg == IDLE && setup)
            wstrb_reg <= pstrb;
    end
`else
    assign strb_skip = 1'b0;
    assign strb_err  = 1'b0;
`endif

    assign setup       = psel && !penable;
    assign timeout_hit = (TIMEOUT != 0) && ((int'(count_reg) + 1) == TIMEOUT);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_reg[i])
                rd_mux = rd_mux | reg_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign read_data = (write_reg || nostrobe_reg) ? '0 : rd_mux;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        sel_next      = sel_reg;
        write_next    = write_reg;
        nostrobe_next = nostrobe_reg;
        wdata_next    = wdata_reg;
        wr_en_next    = '0;
        rd_en_next    = '0;
        pready_next   = 1'b0;
        pslverr_next  = 1'b0;
        prdata_next   = '0;
        case (state_reg)
            IDLE: begin
                if (setup) begin
                    sel_next      = dec_onehot;
                    write_next    = pwrite;
                    wdata_next    = pwdata;
                    nostrobe_next = dec_wo_read || strb_skip;
                    if (dec_err || strb_err) begin
                        state_next   = DONE;
                        pready_next  = 1'b1;
                        pslverr_next = 1'b1;
                    end else begin
                        state_next = STROBE;
                        if (!(dec_wo_read || strb_skip)) begin
                            if (pwrite)
                                wr_en_next = dec_onehot;
                            else
                                rd_en_next = dec_onehot;
                        end
                    end
                end
            end
            STROBE, WAIT: begin
                // Master abandoned the transfer; any strobe already went out.
                if (!psel) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (reg_ack) begin
                    state_next   = DONE;
                    count_next   = '0;
                    pready_next  = 1'b1;
                    pslverr_next = reg_err;
                    prdata_next  = reg_err ? '0 : read_data;
                end else if (state_reg == WAIT && timeout_hit) begin
                    state_next   = DONE;
                    count_next   = '0;
                    pready_next  = 1'b1;
                    pslverr_next = 1'b1;
                end else begin
                    state_next = WAIT;
                    if (state_reg == WAIT)
                        count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            sel_reg      <= '0;
            write_reg    <= 1'b0;
            nostrobe_reg <= 1'b0;
            wdata_reg    <= '0;
            wr_en_reg    <= '0;
            rd_en_reg    <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            prdata_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            sel_reg      <= sel_next;
            write_reg    <= write_next;
            nostrobe_reg <= nostrobe_next;
            wdata_reg    <= wdata_next;
            wr_en_reg    <= wr_en_next;
            rd_en_reg    <= rd_en_next;
            pready_reg   <= pready_next;
            pslverr_reg  <= pslverr_next;
            prdata_reg   <= prdata_next;
        end
    end

    assign pready    = pready_reg;
    assign pslverr   = pslverr_reg;
    assign prdata    = prdata_reg;
    assign reg_wr_en = wr_en_reg;
    assign reg_rd_en = rd_en_reg;
    assign reg_wdata = wdata_reg;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed testbench for uart_apb_bridge: write, stalled read, decode errors,
// RO/WO handling, timeout, protocol abort, reset during WAIT.
module tb_uart_apb_bridge;

    logic         pclk;
    logic         preset;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic         pready;
    logic         pslverr;
    logic [31:0]  prdata;
    logic [15:0]  reg_wr_en;
    logic [15:0]  reg_rd_en;
    logic [31:0]  reg_wdata;
    logic [511:0] reg_rdata;
    logic         reg_ack;
    logic         reg_err;
`ifdef UART_APB_PSTRB_EN
    logic [3:0]   pstrb;
    logic [3:0]   reg_wstrb;
    assign pstrb = pwrite ? 4'hF : 4'h0;
`endif

    int checks   = 0;
    int failures = 0;

    uart_apb_bridge #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .NUM_REGS (16),
        .RO_MASK  (16'h0002),
        .WO_MASK  (16'h0004),
        .TIMEOUT  (15)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
`ifdef UART_APB_PSTRB_EN
        .pstrb     (pstrb),
        .reg_wstrb (reg_wstrb),
`endif
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .reg_err   (reg_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic setup(input logic wr, input logic [11:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
    endtask

    task automatic release_bus();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        int lat;
        preset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        reg_ack = 1'b1;
        reg_err = 1'b0;
        for (int i = 0; i < 16; i++)
            reg_rdata[i*32 +: 32] = 32'h1000 + i;
        reg_rdata[32 +: 32] = 32'h1234;

        step();
        step();
        check("rst_pready", pready, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_prdata", prdata, 0);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_rd_en", reg_rd_en, 0);
        check("rst_wdata", reg_wdata, 0);
        preset = 1'b0;
        step();

        // Write 0xA5 to DR, zero-wait backend.
        setup(1'b1, 12'h000, 32'hA5);
        step();
        penable = 1'b1;
        check("wr_strobe", reg_wr_en, 16'h0001);
        check("wr_no_rd", reg_rd_en, 0);
        check("wr_wdata", reg_wdata, 32'hA5);
        check("wr_t1_pready", pready, 0);
        step();
        check("wr_pready", pready, 1);
        check("wr_pslverr", pslverr, 0);
        check("wr_prdata", prdata, 0);
        check("wr_strobe_once", reg_wr_en, 0);
        release_bus();
        step();
        check("wr_pready_drop", pready, 0);

        // Read reg 1 with ack arriving in the third access cycle.
        reg_ack = 1'b0;
        setup(1'b0, 12'h004, 32'h0);
        step();
        penable = 1'b1;
        check("rd_strobe", reg_rd_en, 16'h0002);
        check("rd_no_wr", reg_wr_en, 0);
        step();
        check("rd_strobe_once", reg_rd_en, 0);
        check("rd_t2_pready", pready, 0);
        step();
        reg_ack = 1'b1;
        check("rd_t3_pready", pready, 0);
        step();
        check("rd_pready", pready, 1);
        check("rd_prdata", prdata, 32'h1234);
        check("rd_pslverr", pslverr, 0);
        release_bus();
        step();

        // Out-of-range and misaligned reads: immediate error, no strobe.
        setup(1'b0, 12'h040, 32'h0);
        step();
        penable = 1'b1;
        check("oor_pready", pready, 1);
        check("oor_pslverr", pslverr, 1);
        check("oor_prdata", prdata, 0);
        check("oor_rd_en", reg_rd_en, 0);
        release_bus();
        step();
        setup(1'b0, 12'h006, 32'h0);
        step();
        penable = 1'b1;
        check("mis_pready", pready, 1);
        check("mis_pslverr", pslverr, 1);
        check("mis_rd_en", reg_rd_en, 0);
        release_bus();
        step();

        // Write to read-only reg 1.
        setup(1'b1, 12'h004, 32'h55);
        step();
        penable = 1'b1;
        check("ro_pready", pready, 1);
        check("ro_pslverr", pslverr, 1);
        check("ro_wr_en", reg_wr_en, 0);
        release_bus();
        step();

        // Read of write-only reg 2: no strobe, data 0, no error.
        setup(1'b0, 12'h008, 32'h0);
        step();
        penable = 1'b1;
        check("wo_rd_en", reg_rd_en, 0);
        step();
        check("wo_pready", pready, 1);
        check("wo_pslverr", pslverr, 0);
        check("wo_prdata", prdata, 0);
        release_bus();
        step();

        // Backend never acks: timeout completes at setup+17.
        reg_ack = 1'b0;
        setup(1'b0, 12'h00C, 32'h0);
        step();
        penable = 1'b1;
        lat = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (pready) begin
                lat = c;
                break;
            end
        end
        check("to_latency", lat, 17);
        check("to_pslverr", pslverr, 1);
        check("to_prdata", prdata, 0);

        // Back-to-back read of reg 3 right after DONE.
        step();
        reg_ack = 1'b1;
        setup(1'b0, 12'h00C, 32'h0);
        step();
        penable = 1'b1;
        check("b2b_rd_en", reg_rd_en, 16'h0008);
        step();
        check("b2b_pready", pready, 1);
        check("b2b_prdata", prdata, 32'h1003);
        check("b2b_pslverr", pslverr, 0);
        release_bus();
        step();

        // Reset pulsed while in WAIT.
        reg_ack = 1'b0;
        setup(1'b0, 12'h014, 32'hDEAD);
        step();
        penable = 1'b1;
        check("rstw_rd_en", reg_rd_en, 16'h0020);
        step();
        preset = 1'b1;
        step();
        check("rstw_pready", pready, 0);
        check("rstw_rd_en0", reg_rd_en, 0);
        check("rstw_wdata", reg_wdata, 0);
        preset = 1'b0;
        release_bus();
        reg_ack = 1'b1;
        step();
        check("rstw_no_strobe", reg_rd_en | reg_wr_en, 0);
        setup(1'b1, 12'h000, 32'h77);
        step();
        penable = 1'b1;
        check("post_wr_en", reg_wr_en, 16'h0001);
        check("post_wdata", reg_wdata, 32'h77);
        step();
        check("post_pready", pready, 1);
        check("post_pslverr", pslverr, 0);
        release_bus();
        step();

        // psel drops mid-transfer: no pready.
        reg_ack = 1'b0;
        setup(1'b0, 12'h010, 32'h0);
        step();
        penable = 1'b1;
        check("abort_rd_en", reg_rd_en, 16'h0010);
        release_bus();
        step();
        check("abort_pready1", pready, 0);
        step();
        check("abort_pready2", pready, 0);

        // Second timeout confirms the counter restarted from zero.
        setup(1'b1, 12'h000, 32'h1);
        step();
        penable = 1'b1;
        lat = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (pready) begin
                lat = c;
                break;
            end
        end
        check("to2_latency", lat, 17);
        check("to2_pslverr", pslverr, 1);
        release_bus();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
